mbus_timer: RTL and testbench

- Memory-mapped timer/counter peripheral on the CPU data bus (mbus).
- Sits directly downstream of the cpu2 core and consumes its mbus_aout, mbus_dout and mbus_wen.
- Returns read data combinationally on its own dout, which the system bus mux forwards to the core's mbus_din.
- Provides a prescaled down-counter with auto-reload/one-shot modes, a compare match, an input capture and a level interrupt request.

---
 rtl/mbus_timer_pkg.sv | 34 +++
 rtl/mbus_timer_if.sv | 13 +
 rtl/mbus_timer_sync_edge.sv | 23 ++
 rtl/mbus_timer.sv | 120 ++++++++++++
 tb/tb_mbus_timer.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/mbus_timer_pkg.sv
// Register map constants and shared types for the mbus timer peripheral.
// Offset and bit-index macros stay in macro form so existing flag-index users keep working.
`ifndef MBUS_TIMER_DEFS
`define MBUS_TIMER_DEFS
`define TMR_CTRL   3'd0
`define TMR_PRESC  3'd1
`define TMR_RLD    3'd2
`define TMR_CNT    3'd3
`define TMR_CMP    3'd4
`define TMR_STAT   3'd5
`define TMR_CAPT   3'd6
`define TMR_RUN    0
`define TMR_RELOAD 1
`define TMR_IRQEN  2
`define TMR_UNF    0
`define TMR_CMPM   1
`define TMR_CAPF   2
`endif

package mbus_timer_pkg;
  typedef enum logic [2:0] {
    REG_CTRL  = `TMR_CTRL,
    REG_PRESC = `TMR_PRESC,
    REG_RLD   = `TMR_RLD,
    REG_CNT   = `TMR_CNT,
    REG_CMP   = `TMR_CMP,
    REG_STAT  = `TMR_STAT,
    REG_CAPT  = `TMR_CAPT,
    REG_NONE  = 3'd7
  } tmr_reg_e;

  localparam int unsigned PRESC_W = 16;
  localparam int unsigned FLAG_W  = 3;
endpackage

// File: rtl/mbus_timer_if.sv
// CPU data-bus (mbus) slice seen by a memory-mapped peripheral.
interface mbus_timer_if #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned ADDR_SIZE = 32
);
  logic [ADDR_SIZE-1:0] mbus_aout;
  logic [WIDTH-1:0]     mbus_dout;
  logic                 mbus_wen;
  logic [WIDTH-1:0]     dout;

  modport master (output mbus_aout, output mbus_dout, output mbus_wen, input dout);
  modport slave  (input mbus_aout, input mbus_dout, input mbus_wen, output dout);
endinterface

// File: rtl/mbus_timer_sync_edge.sv
// Two-flop synchroniser followed by an edge register; pulses rise_o for one clock per rising edge.
module sync_edge (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic rise_o
);
  logic s1_q, s2_q, edge_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      edge_q <= 1'b0;
    end else begin
      s1_q   <= d_i;
      s2_q   <= s1_q;
      edge_q <= s2_q;
    end
  end

  assign rise_o = s2_q & ~edge_q;
endmodule

// File: rtl/mbus_timer.sv
// Memory-mapped prescaled down-counter with reload/one-shot, compare, input capture and level irq.
module mbus_timer
  import mbus_timer_pkg::*;
#(
  parameter int unsigned          WIDTH     = 32,
  parameter int unsigned          ADDR_SIZE = 32,
  parameter logic [ADDR_SIZE-1:0] BASE_ADDR = 32'hff10
) (
  input  logic         clk,
  input  logic         reset,
  mbus_timer_if.slave  bus,
  input  logic         cap_in,
  output logic         irq
);
  logic [FLAG_W-1:0]  ctrl_q, ctrl_d, stat_q, stat_d, stat_set;
  logic [PRESC_W-1:0] presc_q, presc_d, pcnt_q, pcnt_d;
  logic [WIDTH-1:0]   rld_q, rld_d, cnt_q, cnt_d, cmp_q, cmp_d, capt_q, capt_d;
  logic               irq_q, irq_d;
  logic               sel, wr, tick, cap_rise;
  tmr_reg_e           reg_sel;

  assign sel     = (bus.mbus_aout[ADDR_SIZE-1:3] == BASE_ADDR[ADDR_SIZE-1:3]);
  assign reg_sel = tmr_reg_e'(bus.mbus_aout[2:0]);
  assign wr      = sel & bus.mbus_wen;
  assign irq     = irq_q;

  sync_edge u_cap_sync (
    .clk_i  (clk),
    .rst_ni (reset),
    .d_i    (cap_in),
    .rise_o (cap_rise)
  );

  always_comb begin
    ctrl_d   = ctrl_q;
    presc_d  = presc_q;
    rld_d    = rld_q;
    cnt_d    = cnt_q;
    cmp_d    = cmp_q;
    capt_d   = capt_q;
    stat_set = '0;
    tick     = ctrl_q[`TMR_RUN] && (pcnt_q == presc_q);

    if (!ctrl_q[`TMR_RUN] || tick) pcnt_d = '0;
    else                           pcnt_d = pcnt_q + PRESC_W'(1);

    if (tick) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - WIDTH'(1);
      end else begin
        stat_set[`TMR_UNF] = 1'b1;
        if (ctrl_q[`TMR_RELOAD]) cnt_d = rld_q;
        else                     ctrl_d[`TMR_RUN] = 1'b0;
      end
      if (cnt_q == cmp_q) stat_set[`TMR_CMPM] = 1'b1;
    end

    if (cap_rise) begin
      capt_d               = cnt_q;
      stat_set[`TMR_CAPF] = 1'b1;
    end

    // Bus writes are applied after the tick so they win; W1C clears are applied before the hardware sets so sets win.
    stat_d = stat_q;
    if (wr) begin
      unique case (reg_sel)
        REG_CTRL:  begin ctrl_d  = bus.mbus_dout[FLAG_W-1:0];  pcnt_d = '0; end
        REG_PRESC: begin presc_d = bus.mbus_dout[PRESC_W-1:0]; pcnt_d = '0; end
        REG_RLD:   rld_d  = bus.mbus_dout;
        REG_CNT:   cnt_d  = bus.mbus_dout;
        REG_CMP:   cmp_d  = bus.mbus_dout;
        REG_STAT:  stat_d = stat_q & ~bus.mbus_dout[FLAG_W-1:0];
        REG_CAPT, REG_NONE: ;
      endcase
    end
    stat_d = stat_d | stat_set;

    irq_d = ctrl_q[`TMR_IRQEN] & (|stat_q);
  end

  always_comb begin
    bus.dout = '0;
    if (sel) begin
      unique case (reg_sel)
        REG_CTRL:  bus.dout = WIDTH'(ctrl_q);
        REG_PRESC: bus.dout = WIDTH'(presc_q);
        REG_RLD:   bus.dout = rld_q;
        REG_CNT:   bus.dout = cnt_q;
        REG_CMP:   bus.dout = cmp_q;
        REG_STAT:  bus.dout = WIDTH'(stat_q);
        REG_CAPT:  bus.dout = capt_q;
        REG_NONE:  bus.dout = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_q  <= '0;
      presc_q <= '0;
      pcnt_q  <= '0;
      rld_q   <= '0;
      cnt_q   <= '0;
      cmp_q   <= '0;
      stat_q  <= '0;
      capt_q  <= '0;
      irq_q   <= 1'b0;
    end else begin
      ctrl_q  <= ctrl_d;
      presc_q <= presc_d;
      pcnt_q  <= pcnt_d;
      rld_q   <= rld_d;
      cnt_q   <= cnt_d;
      cmp_q   <= cmp_d;
      stat_q  <= stat_d;
      capt_q  <= capt_d;
      irq_q   <= irq_d;
    end
  end
endmodule

// File: tb/tb_mbus_timer.sv
// Directed bench for mbus_timer: bus writes at posedge, reads and checks at negedge.
module tb_mbus_timer;
  localparam logic [31:0] BASE = 32'hff10;
  localparam logic [31:0] IDLE = 32'h0;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic cap_in = 1'b0;
  logic irq;
  int unsigned checks = 0;
  int unsigned failures = 0;

  mbus_timer_if #(.WIDTH(32), .ADDR_SIZE(32)) bus ();

  mbus_timer #(.WIDTH(32), .ADDR_SIZE(32), .BASE_ADDR(BASE)) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .cap_in (cap_in),
    .irq    (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Each call consumes exactly one posedge and returns at the following negedge.
  task automatic wr(input logic [2:0] off, input logic [31:0] data);
    bus.mbus_aout = BASE + 32'(off);
    bus.mbus_dout = data;
    bus.mbus_wen  = 1'b1;
    @(negedge clk);
    bus.mbus_wen  = 1'b0;
    bus.mbus_aout = IDLE;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic rd_at(input string tag, input logic [31:0] addr, input logic [31:0] exp);
    bus.mbus_aout = addr;
    #1;
    check(tag, bus.dout, exp);
    bus.mbus_aout = IDLE;
  endtask

  task automatic rd(input string tag, input logic [2:0] off, input logic [31:0] exp);
    rd_at(tag, BASE + 32'(off), exp);
  endtask

  initial begin
    bus.mbus_aout = IDLE;
    bus.mbus_dout = '0;
    bus.mbus_wen  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int unsigned i = 0; i < 8; i++) rd("reset_reg", 3'(i), 32'd0);
    check("reset_irq", 32'(irq), 32'd0);

    // Periodic reload, PRESC=0; CMP=0 also matches at each underflow
    wr(3'd1, 32'd0);
    wr(3'd2, 32'd3);
    wr(3'd3, 32'd3);
    wr(3'd0, 32'd3);
    rd("per_cnt_start", 3'd3, 32'd3);
    for (int unsigned r = 0; r < 2; r++) begin
      step(); rd("per_cnt2", 3'd3, 32'd2);
      step(); rd("per_cnt1", 3'd3, 32'd1);
      step(); rd("per_cnt0", 3'd3, 32'd0);
      if (r == 0) rd("per_stat_pre", 3'd5, 32'd0);
      step(); rd("per_reload", 3'd3, 32'd3);
      rd("per_stat_unf_cmp0", 3'd5, 32'd3);
    end
    rd_at("unsel_dout", BASE + 32'd8 + 32'd2, 32'd0);
    wr(3'd0, 32'd0);
    wr(3'd5, 32'd7);
    rd("per_stop_cnt", 3'd3, 32'd2);
    rd("per_stat_clr", 3'd5, 32'd0);
    rd("off7_read", 3'd7, 32'd0);

    // One-shot, PRESC=1
    wr(3'd1, 32'd1);
    wr(3'd3, 32'd2);
    wr(3'd0, 32'd1);
    rd("os_cnt_a", 3'd3, 32'd2);
    step(); rd("os_cnt_b", 3'd3, 32'd2);
    step(); rd("os_cnt_c", 3'd3, 32'd1);
    step(); rd("os_cnt_d", 3'd3, 32'd1);
    step(); rd("os_cnt_e", 3'd3, 32'd0);
    rd("os_stat_pre", 3'd5, 32'd0);
    step(); rd("os_cnt_f", 3'd3, 32'd0);
    step(); rd("os_stat", 3'd5, 32'd3);
    rd("os_ctrl", 3'd0, 32'd0);
    rd("os_cnt_hold", 3'd3, 32'd0);
    step(); rd("os_cnt_hold2", 3'd3, 32'd0);
    wr(3'd5, 32'd7);
    rd("os_stat_clr", 3'd5, 32'd0);

    // Compare match and irq
    wr(3'd1, 32'd0);
    wr(3'd4, 32'd5);
    wr(3'd3, 32'd7);
    wr(3'd0, 32'd5);
    rd("cmp_cnt7", 3'd3, 32'd7);
    check("cmp_irq0", 32'(irq), 32'd0);
    step(); rd("cmp_cnt6", 3'd3, 32'd6);
    step(); rd("cmp_cnt5", 3'd3, 32'd5);
    rd("cmp_stat_pre", 3'd5, 32'd0);
    step(); rd("cmp_stat", 3'd5, 32'd2);
    rd("cmp_cnt4", 3'd3, 32'd4);
    check("cmp_irq_lag", 32'(irq), 32'd0);
    step(); check("cmp_irq1", 32'(irq), 32'd1);
    wr(3'd5, 32'd2);
    rd("cmp_stat_w1c", 3'd5, 32'd0);
    check("cmp_irq_hold", 32'(irq), 32'd1);
    step(); check("cmp_irq_drop", 32'(irq), 32'd0);
    rd("cmp_cnt1", 3'd3, 32'd1);
    wr(3'd0, 32'd0);
    rd("cmp_stop_cnt", 3'd3, 32'd0);
    rd("cmp_stop_stat", 3'd5, 32'd0);

    // Capture: rise seen at the 3rd edge, snapshot taken before that edge's tick
    wr(3'd3, 32'd100);
    wr(3'd0, 32'd1);
    cap_in = 1'b1;
    step(); step();
    rd("cap_not_yet", 3'd6, 32'd0);
    step();
    rd("cap_value", 3'd6, 32'd98);
    rd("cap_stat", 3'd5, 32'd4);
    rd("cap_cnt", 3'd3, 32'd97);
    cap_in = 1'b0;
    step(); step(); step();
    cap_in = 1'b1;
    step(); step();
    wr(3'd5, 32'd4);
    rd("cap2_value", 3'd6, 32'd92);
    rd("cap2_stat_set_wins", 3'd5, 32'd4);
    rd("cap2_cnt", 3'd3, 32'd91);

    // Collision: bus write to CNT beats the tick
    wr(3'd3, 32'd50);
    rd("coll_cnt50", 3'd3, 32'd50);
    step(); rd("coll_cnt49", 3'd3, 32'd49);
    rd_at("unsel_cnt", BASE + 32'd8 + 32'd3, 32'd0);

    // Reset mid-count overrides a same-cycle CTRL write
    reset = 1'b0;
    wr(3'd0, 32'd7);
    reset = 1'b1;
    for (int unsigned i = 0; i < 7; i++) rd("rst_mid_reg", 3'(i), 32'd0);
    check("rst_mid_irq", 32'(irq), 32'd0);
    step(); rd("rst_mid_cnt_idle", 3'd3, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
